// File: rtl/wbfifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : wbfifo_pkg
// Purpose  : Register map, bit positions and status packing for wbfifo_responder
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wbfifo_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STAT   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_UDF_BIT   = 19;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  localparam int THRESH_RST = 1;

  function automatic logic [31:0] pack_status(
    input logic [15:0] fill,
    input logic        empty,
    input logic        full,
    input logic        ovf,
    input logic        udf
  );
    logic [31:0] s;
    s                 = '0;
    s[15:0]           = fill;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_UDF_BIT]   = udf;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfifo_core.sv
//------------------------------------------------------------------------------
// Module   : sfifo_core
// Purpose  : Single-clock circular word buffer with push/pop/flush and fill count
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sfifo_core #(
  parameter int DW     = 32,
  parameter int LGFLEN = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DW-1:0]     i_wdata,
  output logic [DW-1:0]     o_rdata,
  output logic [LGFLEN:0]   o_count,
  output logic [LGFLEN:0]   o_count_next,
  output logic              o_full,
  output logic              o_empty
);

  localparam int              DEPTH  = 1 << LGFLEN;
  localparam logic [LGFLEN:0] C_FULL = (LGFLEN+1)'(DEPTH);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [LGFLEN-1:0] r_wr_ptr;
  logic [LGFLEN-1:0] r_rd_ptr;
  logic [LGFLEN:0]   r_count;
  logic [LGFLEN:0]   w_count_next;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == C_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_comb begin
    w_count_next = r_count;
    if (i_flush)
      w_count_next = '0;
    else if (w_do_push)
      w_count_next = r_count + 1'b1;
    else if (w_do_pop)
      w_count_next = r_count - 1'b1;
  end

  // Pointers are LGFLEN bits wide, so wrap-around is the natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata      = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

`default_nettype wire

// File: rtl/wbfifo_responder.sv
//------------------------------------------------------------------------------
// Module   : wbfifo_responder
// Purpose  : Pipelined Wishbone responder fronting a word FIFO with level IRQ.
//            Define WBFIFO_ERR_EN to answer full-write/empty-read with err.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wbfifo_responder
  import wbfifo_pkg::*;
#(
  parameter int DW     = 32,
  parameter int LGFLEN = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_swb_cyc,
  input  logic          i_swb_stb,
  input  logic          i_swb_we,
  input  logic [1:0]    i_swb_addr,
  input  logic [DW-1:0] i_swb_data,
  output logic          o_swb_ack,
  output logic          o_swb_stall,
  output logic          o_swb_err,
  output logic [DW-1:0] o_swb_data,
  output logic          o_interrupt
);

  logic [DW-1:0]   w_fifo_rdata;
  logic [LGFLEN:0] w_count;
  logic [LGFLEN:0] w_count_next;
  logic            w_full;
  logic            w_empty;

  logic            w_req;
  logic            w_is_data;
  logic            w_blocked;
  logic            w_stall;
  logic            w_bad;
  logic            w_sticky_set;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_ctrl_wr;
  logic            w_flush;
  logic            w_clear;
  logic            w_thresh_wr;
  logic [LGFLEN:0] w_thresh_next;
  logic [DW-1:0]   w_rd_word;

  logic            r_ack;
  logic            r_ovf;
  logic            r_udf;
  logic            r_irq;
  logic [LGFLEN:0] r_thresh;
  logic [DW-1:0]   r_data;

  assign w_req     = i_swb_cyc && i_swb_stb;
  assign w_is_data = (i_swb_addr == ADDR_DATA);
  assign w_blocked = w_is_data && (i_swb_we ? w_full : w_empty);

`ifdef WBFIFO_ERR_EN
  logic r_err;

  assign w_stall      = 1'b0;
  assign w_bad        = w_req && w_blocked;
  assign w_sticky_set = w_bad;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_err <= 1'b0;
    else
      r_err <= w_bad;
  end

  assign o_swb_err = r_err && i_swb_cyc;
`else
  assign w_stall      = i_swb_stb && w_blocked;
  assign w_bad        = 1'b0;
  assign w_sticky_set = w_req && w_stall;
  assign o_swb_err    = 1'b0;
`endif

  assign w_accept    = w_req && !w_stall;
  assign w_push      = w_accept && i_swb_we && w_is_data && !w_bad;
  assign w_pop       = w_accept && !i_swb_we && w_is_data && !w_bad;
  assign w_ctrl_wr   = w_accept && i_swb_we && (i_swb_addr == ADDR_CTRL);
  assign w_flush     = w_ctrl_wr && i_swb_data[CTRL_FLUSH_BIT];
  assign w_clear     = w_ctrl_wr && i_swb_data[CTRL_CLR_BIT];
  assign w_thresh_wr = w_accept && i_swb_we && (i_swb_addr == ADDR_THRESH);

  assign w_thresh_next = w_thresh_wr ? i_swb_data[LGFLEN:0] : r_thresh;

  sfifo_core #(
    .DW     (DW),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_wdata      (i_swb_data),
    .o_rdata      (w_fifo_rdata),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_comb begin
    w_rd_word = '0;
    case (i_swb_addr)
      ADDR_DATA:   w_rd_word = w_bad ? '0 : w_fifo_rdata;
      ADDR_STAT:   w_rd_word = DW'(pack_status(16'(w_count), w_empty, w_full, r_ovf, r_udf));
      ADDR_THRESH: w_rd_word = DW'(r_thresh);
      default:     w_rd_word = '0;
    endcase
  end

  // Set wins over clear so a stall in the clearing cycle is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_irq    <= 1'b0;
      r_thresh <= (LGFLEN+1)'(THRESH_RST);
    end else begin
      r_ack    <= w_accept && !w_bad;
      r_data   <= (w_accept && !i_swb_we) ? w_rd_word : '0;
      r_thresh <= w_thresh_next;
      r_irq    <= (w_count_next >= w_thresh_next) && (w_thresh_next != '0);
      if (w_clear) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_sticky_set && i_swb_we)
        r_ovf <= 1'b1;
      if (w_sticky_set && !i_swb_we)
        r_udf <= 1'b1;
    end
  end

  // A master that drops cyc before the response gets no ack.
  assign o_swb_ack   = r_ack && i_swb_cyc;
  assign o_swb_stall = w_stall;
  assign o_swb_data  = r_data;
  assign o_interrupt = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wbfifo_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_wbfifo_responder
// Purpose  : Self-checking bench for wbfifo_responder (default build)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wbfifo_responder;
  import wbfifo_pkg::*;

  localparam int DW     = 32;
  localparam int LGFLEN = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc   = 1'b0;
  logic          stb   = 1'b0;
  logic          we    = 1'b0;
  logic [1:0]    addr  = 2'd0;
  logic [DW-1:0] wdata = '0;
  logic          ack;
  logic          stall;
  logic          err;
  logic [DW-1:0] rdata;
  logic          irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] bvals[3];

  always #5 clk = ~clk;

  wbfifo_responder #(
    .DW     (DW),
    .LGFLEN (LGFLEN)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_swb_cyc   (cyc),
    .i_swb_stb   (stb),
    .i_swb_we    (we),
    .i_swb_addr  (addr),
    .i_swb_data  (wdata),
    .o_swb_ack   (ack),
    .o_swb_stall (stall),
    .o_swb_err   (err),
    .o_swb_data  (rdata),
    .o_interrupt (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // One request, response sampled mid-cycle one clock after acceptance.
  task automatic single(input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic got_ack);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    got_ack = ack;
    rd      = rdata;
    cyc     = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic        k;
    single(1'b1, a, d, x, k);
    check("wr_ack", {31'b0, k}, 32'd1);
  endtask

  task automatic rdchk(input logic [1:0] a, input logic [31:0] e, input string name);
    logic [31:0] x;
    logic        k;
    single(1'b0, a, 32'h0, x, k);
    check({name, "_ack"}, {31'b0, k}, 32'd1);
    check(name, x, e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, ADDR_STAT,   32'h0,         32'h0001_0000, 1'b0};
    vecs[1]  = '{1'b0, ADDR_THRESH, 32'h0,         32'h0000_0001, 1'b0};
    vecs[2]  = '{1'b0, ADDR_CTRL,   32'h0,         32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, ADDR_THRESH, 32'hFFFF_FFE3, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, ADDR_THRESH, 32'h0,         32'h0000_0023, 1'b0};
    vecs[5]  = '{1'b1, ADDR_THRESH, 32'h0000_0002, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, ADDR_DATA,   32'hA5A5_0001, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, ADDR_DATA,   32'h0000_BEEF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, ADDR_STAT,   32'h0,         32'h0000_0002, 1'b1};
    vecs[9]  = '{1'b0, ADDR_DATA,   32'h0,         32'hA5A5_0001, 1'b0};
    vecs[10] = '{1'b0, ADDR_DATA,   32'h0,         32'h0000_BEEF, 1'b0};
    vecs[11] = '{1'b0, ADDR_STAT,   32'h0,         32'h0001_0000, 1'b0};
    bvals[0] = 32'h11; bvals[1] = 32'h22; bvals[2] = 32'h33;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack",   {31'b0, ack},   32'd0);
    check("rst_err",   {31'b0, err},   32'd0);
    check("rst_irq",   {31'b0, irq},   32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_data",  rdata,          32'd0);

    // Table of single transactions
    for (int i = 0; i < 12; i++) begin
      logic [31:0] x;
      logic        k;
      single(vecs[i].we, vecs[i].addr, vecs[i].wdata, x, k);
      check($sformatf("vec%0d_ack", i), {31'b0, k}, 32'd1);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      if (!vecs[i].we)
        check($sformatf("vec%0d_data", i), x, vecs[i].exp_data);
    end

    // Pipelined push x3 then pop x3
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) check("burst_ack", {31'b0, ack}, 32'd1);
      if (i > 3) check("burst_data", rdata, bvals[i-4]);
      if (i < 6) begin
        cyc = 1'b1; stb = 1'b1; we = (i < 3); addr = ADDR_DATA; wdata = bvals[i % 3];
      end else begin
        stb = 1'b0;
      end
    end
    @(negedge clk);
    check("burst_ack_end", {31'b0, ack}, 32'd0);
    cyc = 1'b0;
    rdchk(ADDR_STAT, 32'h0001_0000, "burst_stat");

    // Fill and overflow
    for (int i = 0; i < 32; i++) wr(ADDR_DATA, 32'h1000 + i);
    rdchk(ADDR_STAT, 32'h0002_0020, "full_stat");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = ADDR_DATA; wdata = 32'hDEAD;
    #1 check("ovf_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    check("ovf_stall_held", {31'b0, stall}, 32'd1);
    check("ovf_no_ack",     {31'b0, ack},   32'd0);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("ovf_no_ack2", {31'b0, ack}, 32'd0);
    rdchk(ADDR_STAT, 32'h0006_0020, "ovf_stat");

    // Flush, then read when empty
    wr(ADDR_CTRL, 32'h1);
    rdchk(ADDR_STAT, 32'h0005_0000, "flush_stat");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ADDR_DATA;
    #1 check("udf_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    check("udf_no_ack", {31'b0, ack}, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    rdchk(ADDR_STAT, 32'h000D_0000, "udf_stat");
    wr(ADDR_CTRL, 32'h2);
    rdchk(ADDR_STAT, 32'h0001_0000, "clr_stat");

    // Threshold interrupt
    wr(ADDR_THRESH, 32'd4);
    for (int i = 0; i < 3; i++) begin
      wr(ADDR_DATA, 32'hC0 + i);
      check("irq_below", {31'b0, irq}, 32'd0);
    end
    wr(ADDR_DATA, 32'hC3);
    check("irq_at", {31'b0, irq}, 32'd1);
    rdchk(ADDR_DATA, 32'hC0, "irq_pop");
    check("irq_drop", {31'b0, irq}, 32'd0);
    wr(ADDR_CTRL, 32'h1);

    // Pointer wrap across two passes
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) wr(ADDR_DATA, 32'h100 * (p + 1) + i);
      for (int i = 0; i < 20; i++) rdchk(ADDR_DATA, 32'h100 * (p + 1) + i, "wrap_data");
    end
    for (int i = 0; i < 5; i++) wr(ADDR_DATA, 32'h50 + i);
    wr(ADDR_CTRL, 32'h1);
    rdchk(ADDR_STAT, 32'h0001_0000, "flush5_stat");

    // Cycle dropped before response: no ack, push still happens
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = ADDR_DATA; wdata = 32'hDD;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("drop_no_ack", {31'b0, ack}, 32'd0);
    rdchk(ADDR_STAT, 32'h0000_0001, "drop_stat");
    rdchk(ADDR_DATA, 32'hDD, "drop_data");

    // Async reset between accept and ack
    wr(ADDR_THRESH, 32'd2);
    wr(ADDR_DATA, 32'hE0);
    wr(ADDR_DATA, 32'hE1);
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ADDR_THRESH;
    @(posedge clk);
    #2 rst_n = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("midrst_ack",  {31'b0, ack}, 32'd0);
    check("midrst_irq",  {31'b0, irq}, 32'd0);
    check("midrst_err",  {31'b0, err}, 32'd0);
    check("midrst_data", rdata,        32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ack", {31'b0, ack}, 32'd0);
    cyc = 1'b0;
    rdchk(ADDR_THRESH, 32'h1,         "postrst_thresh");
    rdchk(ADDR_STAT,   32'h0001_0000, "postrst_stat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
